// File: rtl/bram32_lsu_if.sv
// ----------------------------------------------------------------------------
// bram32_lsu_if
//
// Purpose: bundles the CPU request/response handshake and the BRAM port of the
// bram32_lsu load/store unit into one interface.
//
// Signals (names keep the LSU's point of view: i_* into the LSU, o_* out):
//   Request  : i_req_valid, o_req_ready, i_req_we, i_req_addr (byte address),
//              i_req_size, i_req_unsigned, i_req_wdata
//   Response : o_rsp_valid, o_rsp_rdata, o_rsp_err
//   BRAM     : o_mem_addr (word), o_mem_wdata, o_mem_we, o_mem_wr_subaddr,
//              i_mem_rdata (registered read of the previous cycle's address)
//
// Modports:
//   slave  - the LSU itself
//   master - the environment (CPU pipeline plus BRAM)
// ----------------------------------------------------------------------------
interface bram32_lsu_if #(
  parameter int DEPTH = 512
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [ADDR_WIDTH+1:0] i_req_addr;
  logic [1:0]            i_req_size;
  logic                  i_req_unsigned;
  logic [31:0]           i_req_wdata;

  logic                  o_rsp_valid;
  logic [31:0]           o_rsp_rdata;
  logic                  o_rsp_err;

  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [31:0]           o_mem_wdata;
  logic                  o_mem_we;
  logic [2:0]            o_mem_wr_subaddr;
  logic [31:0]           i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned,
           i_req_wdata, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_mem_addr, o_mem_wdata, o_mem_we, o_mem_wr_subaddr
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned,
           i_req_wdata, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_mem_addr, o_mem_wdata, o_mem_we, o_mem_wr_subaddr
  );
endinterface

// File: rtl/bram32_lsu.sv
// ----------------------------------------------------------------------------
// bram32_lsu
//
// Purpose: load/store initiator for a 32-bit BRAM with byte subaddressing.
// Byte-addressed CPU requests are turned into a BRAM word address, a write
// subaddress and LSB-aligned write data; load data is lane-selected and sign-
// or zero-extended, and every request completes with a one-cycle response
// pulse (o_rsp_err flags misaligned or reserved-size requests).
//
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset
//   bus    - bram32_lsu_if.slave: request handshake, response pulse, BRAM port
//
// Parameters:
//   DEPTH  - BRAM depth in 32-bit words (power of two)
//
// Optional feature (compile-time macro BRAM32_LSU_MISALIGN_SPLIT_EN):
//   when defined, misaligned half/word accesses are completed instead of
//   rejected: loads read two consecutive words and merge them, stores are
//   broken into single-byte writes. Word addresses wrap modulo DEPTH.
// ----------------------------------------------------------------------------
module bram32_lsu #(
  parameter int DEPTH = 512
) (
  input logic         i_clk,
  input logic         i_rst,
  bram32_lsu_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int BA_WIDTH   = ADDR_WIDTH + 2;

`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {IDLE, RD_DATA, RESP, SPLIT_RD, SPLIT_WR} state_e;
`else
  typedef enum logic [1:0] {IDLE, RD_DATA, RESP} state_e;
`endif

  state_e                state_q, state_d;
  logic [BA_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [31:0]           rspData_q, rspData_d;
  logic                  rspErr_q, rspErr_d;

`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           firstWord_q, firstWord_d;
  logic [1:0]            byteIdx_q, byteIdx_d;
  logic [BA_WIDTH-1:0]   splitAddr;
  logic [ADDR_WIDTH-1:0] nextWord;
  logic [1:0]            lastIdx;
  logic                  curMisaligned;
`endif

  logic [1:0]            reqOff;
  logic [ADDR_WIDTH-1:0] reqWord;
  logic                  reqMisaligned;
  logic                  reqBadSize;
  logic [63:0]           loadWindow;
  logic [31:0]           loadLane;

  logic                  ready;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [31:0]           memWdata;
  logic [2:0]            memSub;

  // Extends the selected load lane to 32 bits; word loads pass through.
  function automatic logic [31:0] extendLoad(input logic [31:0] lane,
                                             input logic [1:0]  size,
                                             input logic        uns);
    case (size)
      2'd0:    return uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'd1:    return uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  // BRAM subaddress for an aligned store: 1 = word, 2/3 = half, 4..7 = byte.
  function automatic logic [2:0] alignedSubaddr(input logic [1:0] size,
                                                input logic [1:0] off);
    case (size)
      2'd0:    return {1'b1, off};
      2'd1:    return {2'b01, off[1]};
      default: return 3'd1;
    endcase
  endfunction

  // Request decode: word index, byte offset and legality of the access.
  assign reqOff        = bus.i_req_addr[1:0];
  assign reqWord       = bus.i_req_addr[BA_WIDTH-1:2];
  assign reqBadSize    = (bus.i_req_size == 2'd3);
  assign reqMisaligned = ((bus.i_req_size == 2'd1) && reqOff[0]) ||
                         ((bus.i_req_size == 2'd2) && (reqOff != 2'b00));

  // Load lane selection. Aligned loads only shift within the returned word;
  // a split load places the second word above the first so one right shift
  // by the byte offset lines the access up at bit 0.
`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
  assign curMisaligned = ((size_q == 2'd1) && addr_q[0]) ||
                         ((size_q == 2'd2) && (addr_q[1:0] != 2'b00));
  assign loadWindow    = curMisaligned ? {bus.i_mem_rdata, firstWord_q}
                                       : {32'b0, bus.i_mem_rdata};
  assign splitAddr     = addr_q + BA_WIDTH'(byteIdx_q);
  assign nextWord      = addr_q[BA_WIDTH-1:2] + ADDR_WIDTH'(1);
  assign lastIdx       = (size_q == 2'd1) ? 2'd1 : 2'd3;
`else
  assign loadWindow    = {32'b0, bus.i_mem_rdata};
`endif
  assign loadLane      = 32'(loadWindow >> {addr_q[1:0], 3'b000});

  // Next-state and BRAM port logic. The request is only looked at in IDLE,
  // where its fields are captured; later states work from the latched copy so
  // the CPU may change its inputs freely once the request has been accepted.
  // The response registers default to zero every cycle so rdata/err are only
  // non-zero during the single RESP cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    rspData_d  = 32'b0;
    rspErr_d   = 1'b0;
    ready      = 1'b0;
    memWe      = 1'b0;
    memAddr    = addr_q[BA_WIDTH-1:2];
    memWdata   = 32'b0;
    memSub     = 3'd1;
`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
    wdata_d     = wdata_q;
    firstWord_d = firstWord_q;
    byteIdx_d   = byteIdx_q;
`endif

    case (state_q)
      IDLE: begin
        ready   = 1'b1;
        memAddr = reqWord;
        if (bus.i_req_valid) begin
          addr_d     = bus.i_req_addr;
          size_d     = bus.i_req_size;
          unsigned_d = bus.i_req_unsigned;
`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
          wdata_d    = bus.i_req_wdata;
          byteIdx_d  = 2'd1;
`endif
          if (reqBadSize) begin
            rspErr_d = 1'b1;
            state_d  = RESP;
          end else if (reqMisaligned) begin
`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
            // First byte of a split store goes out right away; the rest
            // follow from SPLIT_WR. Split loads fetch the second word next.
            if (bus.i_req_we) begin
              memWe    = 1'b1;
              memSub   = {1'b1, reqOff};
              memWdata = {24'b0, bus.i_req_wdata[7:0]};
              state_d  = SPLIT_WR;
            end else begin
              state_d  = SPLIT_RD;
            end
`else
            rspErr_d = 1'b1;
            state_d  = RESP;
`endif
          end else if (bus.i_req_we) begin
            memWe    = 1'b1;
            memSub   = alignedSubaddr(bus.i_req_size, reqOff);
            memWdata = bus.i_req_wdata;
            state_d  = RESP;
          end else begin
            state_d  = RD_DATA;
          end
        end
      end

      RD_DATA: begin
        rspData_d = extendLoad(loadLane, size_q, unsigned_q);
        state_d   = RESP;
      end

`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
      // The first word's data arrives now while the following word (wrapping
      // at the top of the BRAM) is addressed.
      SPLIT_RD: begin
        memAddr     = nextWord;
        firstWord_d = bus.i_mem_rdata;
        state_d     = RD_DATA;
      end

      // One byte per cycle; the byte address wraps with the BRAM size.
      SPLIT_WR: begin
        memAddr   = splitAddr[BA_WIDTH-1:2];
        memWe     = 1'b1;
        memSub    = {1'b1, splitAddr[1:0]};
        memWdata  = {24'b0, 8'(wdata_q >> {byteIdx_q, 3'b000})};
        byteIdx_d = byteIdx_q + 2'd1;
        if (byteIdx_q == lastIdx) begin
          state_d = RESP;
        end
      end
`endif

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request/response registers. Reset abandons any operation in
  // flight without producing a response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      rspData_q  <= 32'b0;
      rspErr_q   <= 1'b0;
`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
      wdata_q     <= 32'b0;
      firstWord_q <= 32'b0;
      byteIdx_q   <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      rspData_q  <= rspData_d;
      rspErr_q   <= rspErr_d;
`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
      wdata_q     <= wdata_d;
      firstWord_q <= firstWord_d;
      byteIdx_q   <= byteIdx_d;
`endif
    end
  end

  // Ready and write enable are forced low while reset is held, even though
  // the state register only clears on the next edge.
  assign bus.o_req_ready      = ready & ~i_rst;
  assign bus.o_mem_we         = memWe & ~i_rst;
  assign bus.o_mem_addr       = memAddr;
  assign bus.o_mem_wdata      = memWdata;
  assign bus.o_mem_wr_subaddr = memSub;
  assign bus.o_rsp_valid      = (state_q == RESP);
  assign bus.o_rsp_rdata      = rspData_q;
  assign bus.o_rsp_err        = rspErr_q;

endmodule

// File: tb/tb_bram32_lsu.sv
// ----------------------------------------------------------------------------
// tb_bram32_lsu
//
// Purpose: self-checking bench for bram32_lsu. A behavioural BRAM with byte
// subaddressing and a one-cycle registered read sits on the memory port.
// Stimulus pushes hand-computed responses and BRAM writes into queues; a
// monitor pops and compares them, including the cycle they must appear in.
// Build with BRAM32_LSU_MISALIGN_SPLIT_EN defined to cover the split feature.
// ----------------------------------------------------------------------------
module tb_bram32_lsu;

  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    int          tag;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] sub;
    logic [31:0] data;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        memInit;
  int          cycleCnt;
  int          checks;
  int          failures;
  logic [31:0] mem [DEPTH];
  logic [31:0] memRead;
  rsp_t        rspQ[$];
  wr_t         wrQ[$];

  bram32_lsu_if #(.DEPTH(DEPTH)) bus ();

  bram32_lsu #(.DEPTH(DEPTH)) dut (
    .i_clk (clock),
    .i_rst (reset),
    .bus   (bus)
  );

  // Free-running clock and a cycle counter used to time expected events.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cycleCnt <= cycleCnt + 1;
  end

  // Behavioural BRAM: subaddressed writes, read-first registered read.
  always @(posedge clock) begin
    if (memInit) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      mem[5]   <= 32'h5566_7788;
      mem[511] <= 32'hCAFE_F00D;
    end else if (bus.o_mem_we) begin
      case (bus.o_mem_wr_subaddr)
        3'd1: mem[bus.o_mem_addr]        <= bus.o_mem_wdata;
        3'd2: mem[bus.o_mem_addr][15:0]  <= bus.o_mem_wdata[15:0];
        3'd3: mem[bus.o_mem_addr][31:16] <= bus.o_mem_wdata[15:0];
        3'd4: mem[bus.o_mem_addr][7:0]   <= bus.o_mem_wdata[7:0];
        3'd5: mem[bus.o_mem_addr][15:8]  <= bus.o_mem_wdata[7:0];
        3'd6: mem[bus.o_mem_addr][23:16] <= bus.o_mem_wdata[7:0];
        3'd7: mem[bus.o_mem_addr][31:24] <= bus.o_mem_wdata[7:0];
        default: ;
      endcase
    end
    memRead <= mem[bus.o_mem_addr];
  end

  assign bus.i_mem_rdata = memRead;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cycleCnt);
    end
  endtask

  task automatic expectWrite(input int cyc, input int addr, input int sub,
                             input logic [31:0] data);
    wr_t w;
    w.cyc = cyc; w.addr = addr; w.sub = sub; w.data = data;
    wrQ.push_back(w);
  endtask

  // Response and write monitor: every response pulse and every BRAM write
  // must match the oldest outstanding expectation, cycle included.
  always @(negedge clock) begin
    if (!reset && !memInit) begin
      if (bus.o_rsp_valid) begin
        if (rspQ.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = rspQ.pop_front();
          checkOutput($sformatf("rsp%0d_cycle", e.tag), cycleCnt, e.cyc);
          checkOutput($sformatf("rsp%0d_rdata", e.tag), bus.o_rsp_rdata, e.rdata);
          checkOutput($sformatf("rsp%0d_err", e.tag), {31'b0, bus.o_rsp_err},
                      {31'b0, e.err});
        end
      end
      if (bus.o_mem_we) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_write", {23'b0, bus.o_mem_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wrQ.pop_front();
          checkOutput("wr_cycle", cycleCnt, w.cyc);
          checkOutput("wr_addr", {23'b0, bus.o_mem_addr}, w.addr);
          checkOutput("wr_subaddr", {29'b0, bus.o_mem_wr_subaddr}, w.sub);
          checkOutput("wr_data", bus.o_mem_wdata, w.data);
        end
      end
    end
  end

  // Waits (bounded) for ready, issues one request and records its expected
  // response. Inputs are scrambled every cycle the request is not presented
  // so the DUT must rely on its latched copy.
  task automatic applyStimulus(input logic we, input logic [AW+1:0] addr,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] wdata, input bit expectRsp,
                               input logic [31:0] expRdata, input logic expErr,
                               input int latency, input int tag,
                               output int acceptCycle);
    bit gotReady = 1'b0;
    acceptCycle = -1000;
    for (int i = 0; i < 20 && !gotReady; i++) begin
      @(posedge clock); #1;
      bus.i_req_valid    = 1'b0;
      bus.i_req_we       = 1'($urandom);
      bus.i_req_addr     = (AW+2)'($urandom);
      bus.i_req_size     = 2'($urandom);
      bus.i_req_unsigned = 1'($urandom);
      bus.i_req_wdata    = $urandom;
      if (bus.o_req_ready) gotReady = 1'b1;
    end
    if (!gotReady) begin
      checkOutput($sformatf("req%0d_ready_timeout", tag), 32'd0, 32'd1);
    end else begin
      rsp_t e;
      bus.i_req_valid    = 1'b1;
      bus.i_req_we       = we;
      bus.i_req_addr     = addr;
      bus.i_req_size     = size;
      bus.i_req_unsigned = uns;
      bus.i_req_wdata    = wdata;
      acceptCycle        = cycleCnt;
      if (expectRsp) begin
        e.cyc = cycleCnt + latency; e.rdata = expRdata; e.err = expErr; e.tag = tag;
        rspQ.push_back(e);
      end
    end
  endtask

  initial begin
    int t;
    cycleCnt = 0; checks = 0; failures = 0;
    reset = 1'b1; memInit = 1'b1;
    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_addr = '0;
    bus.i_req_size = 2'd0; bus.i_req_unsigned = 1'b0; bus.i_req_wdata = 32'h0;

    // Reset behaviour: nothing accepted or written while reset is held.
    @(posedge clock); #1;
    memInit = 1'b0;
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1;
    @(negedge clock);
    checkOutput("reset_ready", {31'b0, bus.o_req_ready}, 32'd0);
    checkOutput("reset_we", {31'b0, bus.o_mem_we}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; bus.i_req_valid = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_ready", {31'b0, bus.o_req_ready}, 32'd1);
    checkOutput("post_reset_rsp_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
    checkOutput("post_reset_rdata", bus.o_rsp_rdata, 32'd0);
    checkOutput("post_reset_err", {31'b0, bus.o_rsp_err}, 32'd0);

    // Aligned word store / load.
    applyStimulus(1, 'h10, 2, 0, 32'hDEAD_BEEF, 1, 32'h0, 0, 1, 1, t);
    expectWrite(t, 4, 1, 32'hDEAD_BEEF);
    applyStimulus(0, 'h10, 2, 0, 32'h0, 1, 32'hDEAD_BEEF, 0, 2, 2, t);

    // Byte store and signed/unsigned byte loads.
    applyStimulus(1, 'h13, 0, 0, 32'h0000_005A, 1, 32'h0, 0, 1, 3, t);
    expectWrite(t, 4, 7, 32'h0000_005A);
    applyStimulus(0, 'h13, 0, 0, 32'h0, 1, 32'h0000_005A, 0, 2, 4, t);
    applyStimulus(1, 'h13, 0, 0, 32'h0000_0080, 1, 32'h0, 0, 1, 5, t);
    expectWrite(t, 4, 7, 32'h0000_0080);
    applyStimulus(0, 'h13, 0, 0, 32'h0, 1, 32'hFFFF_FF80, 0, 2, 6, t);
    applyStimulus(0, 'h13, 0, 1, 32'h0, 1, 32'h0000_0080, 0, 2, 7, t);

    // Half-word lanes of 0x8001_1234 and byte lanes inside it.
    applyStimulus(1, 'h10, 2, 0, 32'h8001_1234, 1, 32'h0, 0, 1, 8, t);
    expectWrite(t, 4, 1, 32'h8001_1234);
    applyStimulus(0, 'h12, 1, 0, 32'h0, 1, 32'hFFFF_8001, 0, 2, 9, t);
    applyStimulus(0, 'h10, 1, 0, 32'h0, 1, 32'h0000_1234, 0, 2, 10, t);
    applyStimulus(0, 'h12, 1, 1, 32'h0, 1, 32'h0000_8001, 0, 2, 11, t);
    applyStimulus(0, 'h11, 0, 0, 32'h0, 1, 32'h0000_0012, 0, 2, 12, t);

    // Upper-half store into preloaded word 5 (0x5566_7788 -> 0xBEEF_7788).
    applyStimulus(1, 'h16, 1, 0, 32'h0000_BEEF, 1, 32'h0, 0, 1, 13, t);
    expectWrite(t, 5, 3, 32'h0000_BEEF);
    applyStimulus(0, 'h16, 1, 1, 32'h0, 1, 32'h0000_BEEF, 0, 2, 14, t);
    applyStimulus(0, 'h16, 1, 0, 32'h0, 1, 32'hFFFF_BEEF, 0, 2, 15, t);
    applyStimulus(0, 'h14, 2, 0, 32'h0, 1, 32'hBEEF_7788, 0, 2, 16, t);

    // Reserved size is rejected in every build.
    applyStimulus(0, 'h20, 3, 0, 32'h0, 1, 32'h0, 1, 1, 17, t);
    applyStimulus(1, 'h20, 3, 0, 32'h1234_5678, 1, 32'h0, 1, 1, 18, t);

`ifdef BRAM32_LSU_MISALIGN_SPLIT_EN
    // Misaligned accesses complete through the split path.
    applyStimulus(0, 'h11, 2, 0, 32'h0, 1, 32'h8880_0112, 0, 3, 19, t);
    applyStimulus(1, 'h03, 1, 0, 32'h0000_ABCD, 1, 32'h0, 0, 2, 20, t);
    expectWrite(t, 0, 7, 32'h0000_00CD);
    expectWrite(t + 1, 1, 4, 32'h0000_00AB);
    applyStimulus(0, 'h03, 1, 1, 32'h0, 1, 32'h0000_ABCD, 0, 3, 21, t);
    applyStimulus(0, 'h03, 1, 0, 32'h0, 1, 32'hFFFF_ABCD, 0, 3, 22, t);
    // Word store straddling the top of the BRAM wraps to word 0.
    applyStimulus(1, 11'h7FE, 2, 0, 32'h1122_3344, 1, 32'h0, 0, 4, 23, t);
    expectWrite(t,     511, 6, 32'h0000_0044);
    expectWrite(t + 1, 511, 7, 32'h0000_0033);
    expectWrite(t + 2, 0,   4, 32'h0000_0022);
    expectWrite(t + 3, 0,   5, 32'h0000_0011);
    applyStimulus(0, 11'h7FE, 2, 0, 32'h0, 1, 32'h1122_3344, 0, 3, 24, t);
`else
    // Misaligned accesses are rejected with no BRAM write.
    applyStimulus(0, 'h11, 2, 0, 32'h0, 1, 32'h0, 1, 1, 19, t);
    applyStimulus(1, 'h03, 1, 0, 32'h0000_ABCD, 1, 32'h0, 1, 1, 20, t);
    applyStimulus(0, 'h01, 1, 0, 32'h0, 1, 32'h0, 1, 1, 21, t);
    applyStimulus(1, 11'h7FE, 2, 0, 32'h1122_3344, 1, 32'h0, 1, 1, 22, t);
    applyStimulus(0, 'h03, 0, 1, 32'h0, 1, 32'h0000_0000, 0, 2, 23, t);
`endif

    // Reset while the load is in RD_DATA: no response may follow.
    applyStimulus(0, 'h10, 2, 0, 32'h0, 0, 32'h0, 0, 2, 30, t);
    @(posedge clock); #1;
    bus.i_req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_ready", {31'b0, bus.o_req_ready}, 32'd0);
    checkOutput("midreset_we", {31'b0, bus.o_mem_we}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("after_midreset_ready", {31'b0, bus.o_req_ready}, 32'd1);
    checkOutput("after_midreset_rsp_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
    checkOutput("after_midreset_rdata", bus.o_rsp_rdata, 32'd0);
    checkOutput("after_midreset_err", {31'b0, bus.o_rsp_err}, 32'd0);
    checkOutput("after_midreset_we", {31'b0, bus.o_mem_we}, 32'd0);
    @(negedge clock);
    checkOutput("no_late_rsp", {31'b0, bus.o_rsp_valid}, 32'd0);

    // The unit recovers normally after the abandoned load.
    applyStimulus(0, 'h10, 2, 0, 32'h0, 1, 32'h8001_1234, 0, 2, 31, t);

    // Drain and make sure every expectation was consumed.
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      bus.i_req_valid = 1'b0;
    end
    @(negedge clock);
    checkOutput("rsp_queue_empty", rspQ.size(), 32'd0);
    checkOutput("wr_queue_empty", wrQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bram32_lsu.md
Name: bram32_lsu

Overview:
- Load/store initiator that drives a 32-bit byte-subaddressed BRAM port: one word address, one 3-bit write subaddress, 1-cycle registered read.
- Accepts byte-addressed load/store requests from the CPU pipeline over a valid/ready handshake.
- Translates each request into BRAM word address, write subaddress and write data, then extracts and sign/zero-extends load data.
- Returns a one-cycle response pulse.

Parameters:
- DEPTH, 512: BRAM depth in 32-bit words, power of two.
- ADDR_WIDTH, $clog2(DEPTH): word address width; localparam, not overridable.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid & ready
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  ADDR_WIDTH+2  byte address
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- i_req_wdata  in  32  store data, LSB-aligned
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  request rejected, valid with o_rsp_valid
- o_mem_addr  out  ADDR_WIDTH  BRAM word address
- o_mem_wdata  out  32  BRAM write data, LSB-aligned per subaddress
- o_mem_we  out  1  BRAM write enable
- o_mem_wr_subaddr  out  3  1 = word, 2/3 = half0/half1, 4..7 = byte0..byte3 (byte0 = LSB)
- i_mem_rdata  in  32  BRAM read data; reflects the o_mem_addr of the previous cycle

Behaviour:
- Reset values:
  - State IDLE.
  - o_rsp_valid, o_rsp_err, o_rsp_rdata all 0.
  - o_req_ready = 0 and o_mem_we = 0 while i_rst is high.
- States: IDLE, RD_DATA, RESP (plus SPLIT_RD, SPLIT_WR when the optional feature is compiled in).
- o_req_ready = 1 only in IDLE and not in reset. No response backpressure.
- Accept cycle T: o_mem_addr/we/subaddr/wdata are driven combinationally from the request in cycle T. o_mem_we = 0 in every other cycle.
- Aligned store:
  - Subaddress: word -> 1; half -> 2 + addr[1]; byte -> 4 + addr[1:0].
  - o_mem_wdata = i_req_wdata unshifted.
  - Next state RESP; o_rsp_valid at T+1 with rdata 0 and err 0.
- Aligned load:
  - IDLE -> RD_DATA at T; RD_DATA -> RESP at T+1, where lane-select and extension of i_mem_rdata is registered.
  - o_rsp_valid at T+2.
  - Byte = rdata >> 8*addr[1:0]; half = rdata >> 16*addr[1]; then sign- or zero-extend per i_req_unsigned. Word is unchanged.
- Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
- Misaligned or size 3:
  - No memory write.
  - RESP; o_rsp_valid at T+1 with err 1 and rdata 0.
- RESP lasts exactly one cycle, then returns to IDLE. Back-to-back requests are therefore accepted at most every 2 cycles (stores) or 3 cycles (loads).
- Request fields are latched at acceptance. Input changes after T have no effect.
- Reset mid-operation: return to IDLE immediately. No response is emitted. Unissued split bytes are dropped.

Optional Feature:
- Macro: BRAM32_LSU_MISALIGN_SPLIT_EN.
- Without it: misaligned accesses return err as above.
- With it, misaligned half/word accesses complete with err 0.
- Misaligned load:
  - Read word W = addr>>2 at T, and W+1 (mod DEPTH, wraps to 0) at T+1 in SPLIT_RD.
  - Concatenate {second, first} and shift right 8*addr[1:0].
  - Extend and register; o_rsp_valid at T+3.
- Misaligned store:
  - Emitted as n = 2 or 4 single-byte writes in cycles T..T+n-1 (T in IDLE, rest in SPLIT_WR).
  - Byte k = wdata[8k+7:8k] goes to byte address addr+k (word wraps mod DEPTH), subaddr 4 + ((addr+k) & 3).
  - o_rsp_valid at T+n.
- Size 3 still returns err.

Test Plan:
- Store word 0xDEADBEEF to addr 0x10 -> T: mem_addr 4, subaddr 1, we 1; T+1 rsp_valid, err 0. Then load word from 0x10 -> rsp at T+2, rdata 0xDEADBEEF.
- Store byte 0x5A to 0x13, then load signed byte from 0x13 -> subaddr 7; readback 0x0000005A. Store 0x80 to the same address -> signed load 0xFFFFFF80, unsigned load 0x00000080.
- Load signed half from 0x12 with word = 0x8001_1234 -> rdata 0xFFFF8001. Same access at 0x10 -> 0x00001234.
- Without macro: load word from 0x11, store half to 0x03, size 3 -> each gives rsp at T+1 with err 1, rdata 0, no o_mem_we.
- With macro: store word 0x11223344 at byte 4*DEPTH-2 -> byte writes in words DEPTH-1 and 0 (wrap). Load word from same address -> 0x11223344 at T+3.
- Assert i_rst in RD_DATA -> no rsp_valid, ready=0 during reset; next cycle after release IDLE with ready=1 and all outputs 0.
